// File: rtl/rca_config.sv
`default_nettype none
// ============================================================================
//  Package     : rca_config
//  Description : Shared encodings and the request-entry type for the
//                RCA-use decoder. This covers the opcode, the FB/NFB form bit
//                and the buffered entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package rca_config;

    // Custom opcode that carries RCA-use instructions.
    localparam logic [6:0] c_rca_opcode = 7'h2B;

    // Instruction bit selecting the form: 0 = feedback (FB), 1 = no-feedback (NFB).
    localparam int c_fb_bit = 25;

    // Entry fields are sized for the widest legal configuration. funct3 limits
    // the design to eight RCAs, and ids up to eight bits are carried.
    localparam int c_rca_max_w = 3;
    localparam int c_id_max_w  = 8;

    typedef struct packed {
        logic [c_rca_max_w-1:0] rca;
        logic                   fb;
        logic                   abort;
        logic [c_id_max_w-1:0]  id;
    } rca_use_entry_t;

endpackage : rca_config
`default_nettype wire

// File: rtl/rca_use_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rca_use_fifo
//  Description : Small in-order request buffer for the RCA-use decoder.
//                DEPTH must be a power of two. flush empties the buffer and
//                overrides any push or pop in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_use_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Storage array; contents are only observed while the buffer is non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule : rca_use_fifo
`default_nettype wire

// File: rtl/rca_use_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rca_use_decoder
//  Description : Decodes RCA-use instructions, checks that each feedback-form
//                instruction is followed by its no-feedback partner, and
//                buffers dispatch requests to the RCA unit.
//                Optional feature macro: RCA_USE_COUNT_EN adds per-RCA
//                saturating use counters (cnt_value reads 0 without it).
//                NUM_RCAS must be 2..8 and ID_W must be at most 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_use_decoder
    import rca_config::*;
#(
    parameter int NUM_RCAS   = 4,
    parameter int ID_W       = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_valid,
    input  logic [31:0]                 instr,
    input  logic [ID_W-1:0]             instr_id,
    output logic                        instr_ready,
    input  logic                        flush,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [$clog2(NUM_RCAS)-1:0] req_rca,
    output logic                        req_fb,
    output logic                        req_abort,
    output logic [ID_W-1:0]             req_id,
    output logic                        pair_err,
    input  logic                        err_clr,
    input  logic [$clog2(NUM_RCAS)-1:0] cnt_sel,
    output logic [CNT_W-1:0]            cnt_value
);

    localparam int         c_rca_w    = $clog2(NUM_RCAS);
    localparam logic [3:0] c_num_rcas = 4'(NUM_RCAS);

    // Pairing FSM: idle, or waiting for the NFB partner of r_exp.
    localparam logic c_st_idle     = 1'b0;
    localparam logic c_st_wait_nfb = 1'b1;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [c_rca_w-1:0] w_rca;
    logic               w_fb;
    logic               w_is_rca;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;

    logic               r_state;
    logic [c_rca_w-1:0] r_exp;
    logic               r_pair_err;
    logic               w_state_nxt;
    logic               w_abort;
    logic               w_err_set;
    logic               w_match;

    rca_use_entry_t                       w_push_entry;
    rca_use_entry_t                       w_head;
    logic [$bits(rca_use_entry_t)-1:0]    w_pop_data;
    logic                                 w_unused_head;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_rca    = w_funct3[c_rca_w-1:0];
    assign w_fb     = ~instr[c_fb_bit];

    assign w_is_rca = (w_opcode == c_rca_opcode)
                   && (instr[24:15] == 10'd0)
                   && (instr[11:7]  == 5'd0)
                   && (instr[31:26] == 6'd0)
                   && ({1'b0, w_funct3} < c_num_rcas);

    assign instr_ready = ~w_full;
    assign w_accept    = instr_valid & w_is_rca & ~w_full & ~flush;

    // Pairing decision for the instruction being presented this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_err_set   = 1'b0;
        w_match     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_fb) begin
                    w_state_nxt = c_st_wait_nfb;
                end else begin
                    w_abort   = 1'b1;
                    w_err_set = 1'b1;
                end
            end
            c_st_wait_nfb: begin
                if (w_fb) begin
                    // A new FB replaces the unfinished one; it is still dispatched.
                    w_err_set   = 1'b1;
                    w_state_nxt = c_st_wait_nfb;
                end else if (w_rca == r_exp) begin
                    w_match     = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_abort     = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Pairing state advances only on accepted instructions; flush forces idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_exp   <= '0;
        end else if (flush) begin
            r_state <= c_st_idle;
            r_exp   <= '0;
        end else if (w_accept) begin
            r_state <= w_state_nxt;
            r_exp   <= w_rca;
        end
    end

    // Sticky violation flag; a new violation wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_err <= 1'b0;
        end else if (w_accept && w_err_set) begin
            r_pair_err <= 1'b1;
        end else if (err_clr) begin
            r_pair_err <= 1'b0;
        end
    end

    assign pair_err = r_pair_err;

    // Assemble the buffered request from the decoded instruction.
    always_comb begin
        w_push_entry       = '0;
        w_push_entry.rca   = w_funct3;
        w_push_entry.fb    = w_fb;
        w_push_entry.abort = w_abort;
        w_push_entry.id    = c_id_max_w'(instr_id);
    end

    rca_use_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rca_use_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_accept),
        .push_data (w_push_entry),
        .full      (w_full),
        .pop       (req_ready),
        .pop_data  (w_pop_data),
        .empty     (w_empty)
    );

    assign w_head        = rca_use_entry_t'(w_pop_data);
    assign w_unused_head = ^w_head;

    // Request fields read as zero whenever nothing is buffered.
    assign req_valid = ~w_empty;
    assign req_rca   = req_valid ? w_head.rca[c_rca_w-1:0] : '0;
    assign req_fb    = req_valid ? w_head.fb                : 1'b0;
    assign req_abort = req_valid ? w_head.abort             : 1'b0;
    assign req_id    = req_valid ? w_head.id[ID_W-1:0]      : '0;

`ifdef RCA_USE_COUNT_EN
    logic [CNT_W-1:0] r_cnt [NUM_RCAS];

    // Count NFBs that complete a pair, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_accept && w_match && (r_cnt[w_rca] != '1)) begin
            r_cnt[w_rca] <= r_cnt[w_rca] + CNT_W'(1);
        end
    end

    assign cnt_value = r_cnt[cnt_sel];
`else
    logic w_unused_cnt;
    assign w_unused_cnt = w_match ^ (^cnt_sel);
    assign cnt_value    = '0;
`endif

endmodule : rca_use_decoder
`default_nettype wire

// File: doc/rca_use_decoder.md
RCA_USE_DECODER -- requirements
Module: rca_use_decoder

Interface
REQ-001 SHALL have parameter NUM_RCAS, default 4: number of RCAs; funct3 selects the RCA.
REQ-002 SHALL have parameter ID_W, default 3: instruction id width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries, power of two.
REQ-004 SHALL have parameter CNT_W, default 16: per-RCA use-counter width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port instr_valid  in  1  decode-stage instruction present.
REQ-008 SHALL have port instr  in  32  instruction word.
REQ-009 SHALL have port instr_id  in  ID_W  issue id of instr.
REQ-010 SHALL have port instr_ready  out  1  decoder can accept an RCA instruction.
REQ-011 SHALL have port flush  in  1  pipeline flush.
REQ-012 SHALL have port req_valid  out  1  dispatch request to RCA unit.
REQ-013 SHALL have port req_ready  in  1  RCA unit accepts request.
REQ-014 SHALL have port req_rca  out  clog2(NUM_RCAS)  target RCA.
REQ-015 SHALL have port req_fb  out  1  1 = feedback-form, 0 = no-feedback-form.
REQ-016 SHALL have port req_abort  out  1  request violates pairing; RCA discards it.
REQ-017 SHALL have port req_id  out  ID_W  id of the request.
REQ-018 SHALL have port pair_err  out  1  sticky pairing-violation flag.
REQ-019 SHALL have port err_clr  in  1  clears pair_err.
REQ-020 SHALL have ports cnt_sel  in  clog2(NUM_RCAS) and cnt_value  out  CNT_W  use-counter readout.

Function
REQ-021 An instruction SHALL be RCA-use iff opcode 7'h2B, bits[24:15], [11:7] and [31:26] zero, and funct3 < NUM_RCAS; bit 25 = 0 selects FB form, 1 selects NFB form.
REQ-022 An instruction SHALL be accepted when instr_valid, RCA-use, instr_ready and !flush; non-RCA instructions SHALL be ignored.
REQ-023 instr_ready SHALL be !full; an accepted entry SHALL appear on req_* the next cycle; entries SHALL leave in order on req_valid && req_ready.
REQ-024 Push to and pop from a non-full FIFO SHALL occur in the same cycle; count SHALL be unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 The pairing FSM SHALL have states IDLE and WAIT_NFB(exp).
REQ-026 In IDLE, FB(k) SHALL move to WAIT_NFB(k) with abort=0; NFB SHALL set abort=1 and pair_err, remaining in IDLE.
REQ-027 In WAIT_NFB(exp), NFB(exp) SHALL move to IDLE with abort=0; NFB(k != exp) SHALL set abort=1 and pair_err and move to IDLE.
REQ-028 In WAIT_NFB(exp), FB(k) SHALL set pair_err with abort=0 and move to WAIT_NFB(k).
REQ-029 flush SHALL empty the FIFO and force IDLE next cycle, overriding any same-cycle push or pop; counters SHALL be unaffected.
REQ-030 pair_err SHALL give set priority over err_clr in the same cycle.

Reset
REQ-031 While rst_n is low: FSM = IDLE, FIFO empty, req_valid = 0, req_* = 0, pair_err = 0, counters = 0, instr_ready = 1.
REQ-032 Assertion mid-operation SHALL discard in-flight entries immediately; deassertion SHALL be synchronised externally.

Configuration
REQ-033 With RCA_USE_COUNT_EN defined, each RCA SHALL have a CNT_W counter incremented on each accepted matching NFB, saturating at all-ones; cnt_value SHALL be counter[cnt_sel] combinationally.
REQ-034 Without RCA_USE_COUNT_EN, no counters SHALL exist and cnt_value SHALL be 0.

Structure
REQ-035 The opcode 7'h2B, the bit-25 FB/NFB position and the rca_use_entry_t typedef (rca, fb, abort, id) SHALL live in rca_config.
REQ-036 The buffer SHALL be one sub-module, rca_use_fifo; the FSM, decode logic and counters SHALL reside in the top module.

Verification
REQ-037 Test: FB 0x0000102B id 1, then NFB 0x0200102B id 2, req_ready = 1 -> two requests (rca 1, fb 1, abort 0) and (rca 1, fb 0, abort 0); cnt_sel = 1 gives 1.
REQ-038 Test: NFB 0x0200202B with no prior FB -> abort = 1, pair_err = 1; err_clr -> 0 next cycle.
REQ-039 Test: FB rca 0, then NFB rca 3 -> second request abort = 1, FSM IDLE, counter 3 = 0.
REQ-040 Test: req_ready = 0 with 2 accepted entries -> instr_ready = 0; a third instruction is not accepted; one pop -> instr_ready = 1.
REQ-041 Test: flush with a full FIFO plus an instr_valid in the same cycle -> req_valid = 0 next cycle, FSM IDLE, nothing enqueued.
REQ-042 Test: preload counter to all-ones (CNT_W = 4, 15 pairs) plus 1 more pair -> value stays 15; rst_n low mid-stream -> all outputs at reset values.
